tnn_neuron_stream: RTL and testbench

Streaming, parametrised threshold neuron for the TNN datapath: it generalises the single-shot 8×2-bit "positive group sum > negative group sum" comparator to LANES inputs per beat and IN_W bits per input. A sample can span up to MAX_BEATS beats, and the decision threshold is set at run time. Beats arrive through a valid/ready handshake and are accumulated as a signed difference. The block returns one decision bit and the raw sum per sample on a valid/ready output. It sits between the input feature buffer and the class-vote stage.

---
 rtl/tnn_neuron_stream.sv | 126 ++++++++++++
 tb/tb_tnn_neuron_stream.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/tnn_neuron_stream.sv
`default_nettype none
// ============================================================================
// tnn_neuron_stream: streaming threshold neuron, signed lane-sum vs threshold
// Revision: 1.0
// ============================================================================
module tnn_neuron_stream #(
  parameter int               IN_W      = 2,
  parameter int               LANES     = 8,
  parameter int               MAX_BEATS = 4,
  parameter logic [LANES-1:0] POS_MASK  = 8'b1000_1001,
  localparam int              ACC_W     = $clog2(LANES*MAX_BEATS*(2**IN_W-1)+1)+1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*IN_W-1:0] in_data,
  input  logic                  in_last,
  input  logic [ACC_W-1:0]      thresh,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_bit,
  output logic [ACC_W-1:0]      out_sum,
  output logic                  out_err
);

  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS-1);

  typedef enum logic [0:0] {ST_ACC = 1'b0, ST_RESULT = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_bit_q, out_bit_d;
  logic signed [ACC_W-1:0]  out_sum_q, out_sum_d;
  logic                     out_err_q, out_err_d;

  logic signed [ACC_W-1:0]  beat_sum;
  logic signed [ACC_W-1:0]  total;
  logic                     beat_hs;
  logic                     end_of_sample;

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      if (POS_MASK[i])
        beat_sum = beat_sum + $signed({{(ACC_W-IN_W){1'b0}}, in_data[i*IN_W +: IN_W]});
      else
        beat_sum = beat_sum - $signed({{(ACC_W-IN_W){1'b0}}, in_data[i*IN_W +: IN_W]});
    end
  end

  assign beat_hs       = in_valid && (state_q == ST_ACC);
  assign total         = acc_q + beat_sum;
  // The final permitted beat closes the sample even without in_last.
  assign end_of_sample = beat_hs && (in_last || (beat_cnt_q == LAST_CNT));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beat_cnt_d  = beat_cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    out_sum_d   = out_sum_q;
    out_err_d   = out_err_q;
    case (state_q)
      ST_ACC: begin
        if (end_of_sample) begin
          out_sum_d   = total;
          out_bit_d   = total > $signed(thresh);
          out_err_d   = !in_last;
          acc_d       = '0;
          beat_cnt_d  = '0;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_RESULT;
        end else if (beat_hs) begin
          acc_d      = total;
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      ST_RESULT: begin
        if (out_ready) begin
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          state_d     = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      beat_cnt_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_sum_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beat_cnt_q  <= beat_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_sum_q   <= out_sum_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_sum   = out_sum_q;
  assign out_err   = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tnn_neuron_stream.sv
`default_nettype none
// Directed bench for tnn_neuron_stream at default parameters (ACC_W = 8).
module tb_tnn_neuron_stream;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_data;
  logic              in_last;
  logic signed [7:0] thresh;
  logic              out_valid;
  logic              out_ready;
  logic              out_bit;
  logic signed [7:0] out_sum;
  logic              out_err;

  int total = 0;
  int bad   = 0;

  tnn_neuron_stream dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .thresh(thresh),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_sum(out_sum), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [15:0] d, input logic l, input logic signed [7:0] t);
    in_valid = 1'b1; in_data = d; in_last = l; thresh = t;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    thresh = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_bit", out_bit, 0);
    check("rst_out_err", out_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // all lanes 3: +9 -15
    beat(16'hFFFF, 1'b1, 8'sd0);
    check("t1_valid", out_valid, 1);
    check("t1_sum", out_sum, -6);
    check("t1_bit", out_bit, 0);
    check("t1_err", out_err, 0);
    consume();
    check("t1_ready_back", in_ready, 1);

    // positive lanes only at 3: sum 9
    beat(16'hC0C3, 1'b1, 8'sd8);
    check("t2_sum", out_sum, 9);
    check("t2_bit_gt", out_bit, 1);
    consume();
    beat(16'hC0C3, 1'b1, 8'sd9);
    check("t2_bit_eq", out_bit, 0);
    consume();

    // three beats of +1
    beat(16'h9596, 1'b0, 8'sd0);
    check("t3_no_result_b1", out_valid, 0);
    beat(16'h9596, 1'b0, 8'sd0);
    beat(16'h9596, 1'b1, 8'sd2);
    check("t3_valid", out_valid, 1);
    check("t3_sum", out_sum, 3);
    check("t3_bit", out_bit, 1);
    check("t3_err", out_err, 0);
    check("t3_in_ready", in_ready, 0);
    consume();

    // four beats, no in_last: forced termination
    for (int i = 0; i < 3; i++) begin
      beat(16'hC0C3, 1'b0, 8'sd0);
      check("t4_pending", out_valid, 0);
    end
    beat(16'hC0C3, 1'b0, 8'sd0);
    check("t4_valid", out_valid, 1);
    check("t4_sum", out_sum, 36);
    check("t4_err", out_err, 1);
    check("t4_bit", out_bit, 1);
    consume();
    beat(16'hC0C3, 1'b1, 8'sd100);
    check("t4_fresh_sum", out_sum, 9);
    check("t4_fresh_err", out_err, 0);
    check("t4_fresh_bit", out_bit, 0);

    // stall in RESULT with upstream holding a beat
    in_valid = 1'b1; in_data = 16'hFFFF; in_last = 1'b1; thresh = 8'sd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t5_stall_valid", out_valid, 1);
      check("t5_stall_sum", out_sum, 9);
      check("t5_stall_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("t5_ready_rise", in_ready, 1);
    check("t5_valid_drop", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    check("t5_next_valid", out_valid, 1);
    check("t5_next_sum", out_sum, -6);
    consume();

    // reset mid-sample
    beat(16'h9596, 1'b0, 8'sd0);
    beat(16'h9596, 1'b0, 8'sd0);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_ready", in_ready, 1);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_sum", out_sum, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    beat(16'hFFFF, 1'b1, 8'sd0);
    check("t6_clean_sum", out_sum, -6);
    check("t6_clean_err", out_err, 0);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
